// File: rtl/srrc_tx_scheduler.sv
// Sequencing controller for the 4-sample/symbol SRRC transmit filter: strobe generation,
// 2-entry symbol buffer, RUN/FLUSH control. Optional macro: TX_UNDERFLOW_CNT_EN.
module srrc_tx_scheduler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FLUSH_SYMS = 78
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stop,
    input  logic        s_valid,
    input  logic [17:0] s_data,
    output logic        s_ready,
    output logic        sam_clk_en,
    output logic        sym_clk_en,
    output logic [17:0] sym_out,
    output logic        busy,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int unsigned SYM_W   = 18;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_SYMS + 1);
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         sam_cnt;
    logic [FLUSH_W-1:0] flush_cnt;

    logic [SYM_W-1:0]   fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic zero_load;
    logic last_flush;

    // Strobes and handshake decode straight from registered state
    assign busy       = (state != IDLE);
    assign sam_clk_en = busy && (div_cnt == '0);
    assign sym_clk_en = sam_clk_en && (sam_cnt == 2'd0);

    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'd2);
    assign s_ready    = !fifo_full && (state != FLUSH);

    assign push       = s_valid && s_ready;
    assign pop        = sym_clk_en && !fifo_empty;
    assign zero_load  = sym_clk_en && fifo_empty;
    assign last_flush = (state == FLUSH) && zero_load
                        && (flush_cnt == FLUSH_W'(FLUSH_SYMS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = stop ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (stop || !enable) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (last_flush) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Phase counters hold at zero in IDLE so every start is at phase 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            sam_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == IDLE) begin
                div_cnt <= '0;
                sam_cnt <= '0;
            end else begin
                div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
                if (sam_clk_en) begin
                    sam_cnt <= sam_cnt + 2'd1;
                end
            end
            if (state != FLUSH) begin
                flush_cnt <= '0;
            end else if (zero_load) begin
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s_data;
        end
    end

    // Occupancy only: full is a register so a pop never reopens s_ready the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_out   <= '0;
            underflow <= 1'b0;
        end else begin
            if (sym_clk_en) begin
                sym_out <= pop ? fifo_mem[rd_ptr] : '0;
            end
            underflow <= (state == RUN) && zero_load;
        end
    end

`ifdef TX_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_cnt <= '0;
        end else if (underflow && (underflow_cnt != {CNT_W{1'b1}})) begin
            underflow_cnt <= underflow_cnt + CNT_W'(1);
        end
    end
`else
    assign underflow_cnt = CNT_W'(0);
`endif

endmodule
